// File: rtl/tcd1304_frame_packer_pkg.sv
// Shared constants and state encodings for the TCD1304 frame packer.
package tcd1304_frame_packer_pkg;

   localparam logic [15:0] HDR_MAGIC = 16'hA5C3;
   localparam int NUM_CH = 10;
   localparam int BEATS_PER_SET = 5;
   localparam int SET_W = NUM_CH * 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_DATA    = 2'd2,
      S_DISCARD = 2'd3
   } out_state_t;

endpackage

// File: rtl/tcd1304_set_fifo.sv
// Small synchronous first-word-fall-through FIFO holding complete pixel sets.
module tcd1304_set_fifo #(
   parameter int WIDTH = 161,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_q[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push && !full) wr_q <= wr_q + 1'b1;
         if (pop && !empty) rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/tcd1304_frame_packer.sv
// Aligns 10-channel TCD1304 samples into pixel sets and serialises frames
// onto a 32-bit AXI4-Stream, flagging skew, sync and overflow faults.
module tcd1304_frame_packer
   import tcd1304_frame_packer_pkg::*;
#(
   parameter int PIXELS     = 3694,
   parameter int SKEW_MAX   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SET_W-1:0]   tcd1304_dout,
   input  logic [NUM_CH-1:0]  tcd1304_valid,
   input  logic [NUM_CH-1:0]  tcd1304_frame_start,
   output logic [31:0]        m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tlast,
   output logic               m_axis_tuser,
   output logic [15:0]        frame_cnt,
   input  logic               err_clr,
   output logic               sync_err,
   output logic               ovf_err,
   output logic               short_frame
);

   localparam int SKW = $clog2(SKEW_MAX + 1);
   localparam logic [15:0] LAST_PIX = 16'(PIXELS - 1);
   localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_SET - 1);

   logic [NUM_CH-1:0] mask_q;
   logic [NUM_CH-1:0] fs_q;
   logic [NUM_CH-1:0] mask_all;
   logic [NUM_CH-1:0] fs_all;
   logic [SET_W-1:0]  data_q;
   logic [SET_W-1:0]  merged;
   logic [SKW-1:0]    skew_q;
   logic              dup;
   logic              complete;
   logic              timeout;
   logic              set_sof;
   logic              sof_bad;
   logic              drop_sof;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [SET_W:0]    head;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign merged[16*k +: 16] = tcd1304_valid[k] ?
         tcd1304_dout[16*k +: 16] : data_q[16*k +: 16];
   end

   assign mask_all = mask_q | tcd1304_valid;
   assign fs_all   = fs_q | (tcd1304_frame_start & tcd1304_valid);
   assign dup      = |(tcd1304_valid & mask_q);
   assign complete = !dup && (&mask_all);
   assign timeout  = !dup && !complete && (mask_q != '0) &&
                     (skew_q == SKW'(SKEW_MAX - 1));
   assign set_sof  = |fs_all;
   assign sof_bad  = complete && set_sof && !(&fs_all);
   assign drop_sof = complete && fifo_full && set_sof;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         fs_q   <= '0;
         data_q <= '0;
         skew_q <= '0;
      end else if (dup || timeout) begin
         // abandoned partial set; this cycle's samples seed the next one
         mask_q <= tcd1304_valid;
         fs_q   <= tcd1304_frame_start & tcd1304_valid;
         data_q <= merged;
         skew_q <= '0;
      end else if (complete) begin
         mask_q <= '0;
         fs_q   <= '0;
         skew_q <= '0;
      end else begin
         mask_q <= mask_all;
         fs_q   <= fs_all;
         data_q <= merged;
         if (mask_q != '0) skew_q <= skew_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_err <= 1'b0;
         ovf_err  <= 1'b0;
      end else begin
         if (dup || timeout || sof_bad) sync_err <= 1'b1;
         else if (err_clr)              sync_err <= 1'b0;
         if (complete && fifo_full)     ovf_err  <= 1'b1;
         else if (err_clr)              ovf_err  <= 1'b0;
      end
   end

   tcd1304_set_fifo #(
      .WIDTH (SET_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (complete && !fifo_full),
      .din   ({set_sof, merged}),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   out_state_t  state;
   logic [2:0]  beat;
   logic [15:0] pix;
   logic        sync_q;
   logic [7:0]  nxt_lo;

   assign nxt_lo = {beat + 3'd1, 5'd0};
   assign pop = (state == S_DISCARD) ||
                (state == S_DATA && beat == LAST_BEAT && m_axis_tready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         beat          <= '0;
         pix           <= '0;
         sync_q        <= 1'b0;
         frame_cnt     <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         short_frame   <= 1'b0;
      end else begin
         if (err_clr) short_frame <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  if (head[SET_W]) begin
                     state         <= S_HDR;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tuser  <= 1'b1;
                     m_axis_tdata  <= {HDR_MAGIC, frame_cnt};
                     if (sync_q) short_frame <= 1'b1;
                  end else if (sync_q) begin
                     state         <= S_DATA;
                     beat          <= '0;
                     m_axis_tvalid <= 1'b1;
                     m_axis_tdata  <= head[31:0];
                  end else begin
                     state <= S_DISCARD;
                  end
               end
            end
            S_HDR: begin
               if (m_axis_tready) begin
                  state        <= S_DATA;
                  beat         <= '0;
                  frame_cnt    <= frame_cnt + 1'b1;
                  pix          <= '0;
                  sync_q       <= 1'b1;
                  m_axis_tuser <= 1'b0;
                  m_axis_tdata <= head[31:0];
               end
            end
            S_DATA: begin
               if (m_axis_tready) begin
                  if (beat == LAST_BEAT) begin
                     state         <= S_IDLE;
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     pix           <= pix + 1'b1;
                     if (pix == LAST_PIX) sync_q <= 1'b0;
                  end else begin
                     beat         <= beat + 1'b1;
                     m_axis_tdata <= head[nxt_lo +: 32];
                     m_axis_tlast <= (beat == LAST_BEAT - 3'd1) &&
                                     (pix == LAST_PIX);
                  end
               end
            end
            S_DISCARD: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
         // a lost frame start leaves the stream out of sync
         if (drop_sof) sync_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tcd1304_frame_packer.sv
// Randomised scoreboard bench for tcd1304_frame_packer against a frame-level model.
module tb_tcd1304_frame_packer;

   localparam int PIX = 4;
   typedef logic [15:0] set_t [10];

   logic         clk = 1'b0;
   logic         rst_n;
   logic [159:0] dout;
   logic [9:0]   valid;
   logic [9:0]   fstart;
   logic [31:0]  tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic         tuser;
   logic [15:0]  frame_cnt;
   logic         err_clr;
   logic         sync_err;
   logic         ovf_err;
   logic         short_frame;

   int vectors = 0;
   int errors = 0;
   bit [33:0] exp_q[$];
   bit m_in_frame = 0;
   int m_pix = 0;
   bit [15:0] m_fcnt = 0;
   bit exp_short = 0;
   bit rand_ready = 0;
   bit fixed_ready = 1;

   always #5 clk = ~clk;

   tcd1304_frame_packer #(
      .PIXELS     (PIX),
      .SKEW_MAX   (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .tcd1304_dout        (dout),
      .tcd1304_valid       (valid),
      .tcd1304_frame_start (fstart),
      .m_axis_tdata        (tdata),
      .m_axis_tvalid       (tvalid),
      .m_axis_tready       (tready),
      .m_axis_tlast        (tlast),
      .m_axis_tuser        (tuser),
      .frame_cnt           (frame_cnt),
      .err_clr             (err_clr),
      .sync_err            (sync_err),
      .ovf_err             (ovf_err),
      .short_frame         (short_frame)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // frame-level reference: header on sof, 5 beats per in-frame set
   function automatic void model_set(input set_t d, input bit sof);
      if (sof) begin
         if (m_in_frame) exp_short = 1;
         exp_q.push_back({2'b10, 16'hA5C3, m_fcnt});
         m_fcnt++;
         m_in_frame = 1;
         m_pix = 0;
      end
      if (m_in_frame) begin
         for (int b = 0; b < 5; b++)
            exp_q.push_back({1'b0, (b == 4 && m_pix == PIX - 1),
                             d[2*b+1], d[2*b]});
         m_pix++;
         if (m_pix == PIX) m_in_frame = 0;
      end
   endfunction

   function automatic set_t rand_set();
      set_t s;
      for (int k = 0; k < 10; k++) s[k] = 16'($urandom);
      return s;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_cycle(input logic [9:0] v, input logic [9:0] fs,
                              input set_t d);
      valid = v;
      fstart = fs;
      for (int k = 0; k < 10; k++) dout[16*k +: 16] = d[k];
      @(posedge clk);
      #1;
      valid = '0;
      fstart = '0;
   endtask

   task automatic send_set(input set_t d, input bit sof, input int skew);
      int off[10];
      logic [9:0] v;
      for (int k = 0; k < 10; k++) off[k] = $urandom_range(0, skew);
      for (int c = 0; c <= skew; c++) begin
         v = '0;
         for (int k = 0; k < 10; k++) if (off[k] == c) v[k] = 1'b1;
         drive_cycle(v, sof ? v : 10'h000, d);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_outstanding", exp_q.size(), 0);
      idle(20);
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      exp_short = 0;
      idle(1);
      chk("clr_sync_err", sync_err, 0);
      chk("clr_ovf_err", ovf_err, 0);
      chk("clr_short_frame", short_frame, 0);
   endtask

   initial begin
      tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready = rand_ready ? ($urandom_range(0, 4) != 0) : fixed_ready;
      end
   end

   bit held = 0;
   bit [33:0] held_v;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 0;
      end else begin
         if (held) begin
            chk("axis_hold_valid", tvalid, 1);
            chk("axis_hold_beat", {tuser, tlast, tdata}, held_v);
         end
         if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_beat: got %0h, required no beat",
                        {tuser, tlast, tdata});
            end else begin
               chk("beat", {tuser, tlast, tdata}, exp_q.pop_front());
            end
         end
         held = tvalid && !tready;
         held_v = {tuser, tlast, tdata};
      end
   end

   initial begin
      set_t d, d2, d3;
      rst_n = 1'b0;
      valid = '0;
      fstart = '0;
      dout = '0;
      err_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_tuser", tuser, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_ovf_err", ovf_err, 0);
      chk("rst_short_frame", short_frame, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // one aligned frame, header then 20 beats
      for (int i = 0; i < 4; i++) begin
         d = rand_set();
         send_set(d, i == 0, 0);
         model_set(d, i == 0);
         idle(3);
      end
      drain();
      chk("frame_cnt_first", frame_cnt, m_fcnt);

      // random skew, frame starts and backpressure
      rand_ready = 1;
      for (int i = 0; i < 60; i++) begin
         bit sof;
         sof = (i == 0) || ($urandom_range(0, 5) == 0);
         d = rand_set();
         send_set(d, sof, $urandom_range(0, 7));
         model_set(d, sof);
         idle($urandom_range(8, 20));
      end
      drain();
      rand_ready = 0;
      chk("rand_sync_err", sync_err, 0);
      chk("rand_ovf_err", ovf_err, 0);
      chk("rand_short_frame", short_frame, exp_short);
      chk("rand_frame_cnt", frame_cnt, m_fcnt);
      clear_errs();

      // skew 10 accepted, skew 20 dropped
      d = rand_set();
      drive_cycle(10'h01F, 10'h01F, d);
      idle(9);
      drive_cycle(10'h3E0, 10'h3E0, d);
      model_set(d, 1);
      drain();
      chk("skew10_sync_err", sync_err, 0);
      d = rand_set();
      drive_cycle(10'h01F, 10'h000, d);
      idle(19);
      drive_cycle(10'h3E0, 10'h000, d);
      idle(40);
      chk("skew20_sync_err", sync_err, 1);

      // duplicate ch3 restarts the set with its second sample
      d = rand_set();
      d2 = rand_set();
      d3 = rand_set();
      d3[3] = d2[3];
      drive_cycle(10'h1FF, 10'h000, d);
      idle(1);
      drive_cycle(10'h008, 10'h000, d2);
      drive_cycle(10'h3F7, 10'h000, d3);
      model_set(d3, 0);
      drain();
      chk("dup_sync_err", sync_err, 1);
      chk("dup_short_frame", short_frame, exp_short);
      clear_errs();

      // long stall overflows the set FIFO
      fixed_ready = 0;
      idle(2);
      for (int i = 0; i < 6; i++) begin
         d = rand_set();
         send_set(d, i == 0, 0);
         if (i < 4) model_set(d, i == 0);
         idle(3);
      end
      idle(2000);
      chk("ovf_err_set", ovf_err, 1);
      chk("ovf_hold_tvalid", tvalid, 1);
      chk("ovf_hold_tuser", tuser, 1);
      chk("ovf_frame_cnt", frame_cnt, m_fcnt - 16'd1);
      fixed_ready = 1;
      drain();
      chk("ovf_frame_cnt_after", frame_cnt, m_fcnt);
      clear_errs();

      // frame start at pixel 2 cuts the frame short
      for (int i = 0; i < 6; i++) begin
         bit sof;
         sof = (i == 0) || (i == 2);
         d = rand_set();
         send_set(d, sof, 3);
         model_set(d, sof);
         idle(10);
      end
      drain();
      chk("short_frame_set", short_frame, exp_short);
      chk("short_frame_cnt", frame_cnt, m_fcnt);

      // sets after the frame ended without a new start are dropped
      for (int i = 0; i < 3; i++) begin
         d = rand_set();
         send_set(d, 0, 2);
         model_set(d, 0);
         idle(10);
      end
      idle(40);
      chk("drop_no_beats", exp_q.size(), 0);
      chk("drop_tvalid", tvalid, 0);
      clear_errs();

      // reset mid-frame abandons the stream
      fixed_ready = 0;
      idle(2);
      d = rand_set();
      send_set(d, 1, 0);
      idle(5);
      chk("pre_reset_tvalid", tvalid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_frame_cnt", frame_cnt, 0);
      idle(2);
      rst_n = 1'b1;
      fixed_ready = 1;
      idle(5);
      chk("post_reset_tvalid", tvalid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
